// File: rtl/div_pkg.sv
// Shared widths, error constant and FSM state encoding for the 16-by-8
// sequential restoring divider.
package div_pkg;
  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  localparam int ITER  = 8;

  localparam logic [DVS_W-1:0] ERR_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/div_sub_stage.sv
// Combinational 9-bit trial subtractor for one restoring-division step;
// borrow set means the trial value was smaller than the divisor.
module div_sub_stage
  import div_pkg::*;
(
  input  logic [DVS_W:0] a,
  input  logic [DVS_W:0] b,
  output logic [DVS_W:0] diff,
  output logic           borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_16by8_seq.sv
// Sequential unsigned radix-2 restoring divider (16-bit / 8-bit), one
// quotient bit per cycle, with valid/ready handshakes on both sides.
module div_16by8_seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  state_t           state;
  state_t           next_state;
  logic [2:0]       cnt;
  logic [DVS_W:0]   r;
  logic [DVS_W-1:0] q_sr;
  logic [DVS_W-1:0] lo_sr;
  logic [DVS_W-1:0] dvs;
  logic             err_dz;
  logic             err_ov;

  logic             accept;
  logic             last;
  logic             err_pend;
  logic             dz_in;
  logic             ov_in;
  logic [DVS_W:0]   shift_in;
  logic [DVS_W:0]   diff;
  logic             borrow;
  logic [DVS_W:0]   next_r;
  logic             r_msb_unused;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == 3'(ITER - 1));
  assign err_pend  = err_dz | err_ov;

  assign dz_in = (divisor == '0);
  assign ov_in = !dz_in && (dividend[DVD_W-1:DVS_W] >= divisor);

  // The invariant r < divisor keeps r[8] zero between steps, so only the
  // low byte feeds the next trial.
  assign shift_in     = {r[DVS_W-1:0], lo_sr[DVS_W-1]};
  assign next_r       = borrow ? shift_in : diff;
  assign r_msb_unused = r[DVS_W];

  div_sub_stage u_sub (
    .a      (shift_in),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Error results still pass through RUN for one cycle so they surface one
  // edge after accept, matching the registered result path.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN:  if (err_pend || last) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      r           <= '0;
      q_sr        <= '0;
      lo_sr       <= '0;
      dvs         <= '0;
      err_dz      <= 1'b0;
      err_ov      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvs    <= divisor;
            r      <= {1'b0, dividend[DVD_W-1:DVS_W]};
            lo_sr  <= dividend[DVS_W-1:0];
            q_sr   <= '0;
            cnt    <= '0;
            err_dz <= dz_in;
            err_ov <= ov_in;
          end
        end
        RUN: begin
          if (err_pend) begin
            quotient    <= ERR_QUOT;
            remainder   <= lo_sr;
            div_by_zero <= err_dz;
            overflow    <= err_ov;
          end else begin
            r     <= next_r;
            lo_sr <= {lo_sr[DVS_W-2:0], 1'b0};
            q_sr  <= {q_sr[DVS_W-2:0], ~borrow};
            cnt   <= cnt + 3'd1;
            if (last) begin
              quotient    <= {q_sr[DVS_W-2:0], ~borrow};
              remainder   <= next_r[DVS_W-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16by8_seq.sv
// Scoreboard bench for div_16by8_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_div_16by8_seq;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  div_16by8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Waits for the DUT to be idle, then presents one operand set for one edge.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs,
                               input bit push, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got q=%0h r=%0h expected none", quotient, remainder);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("div_by_zero", div_by_zero, e.dz);
          checkOutput("overflow", overflow, e.ov);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    logic [15:0] dvd;
    logic [7:0]  dvs, hi;
    int   k;
    exp_t e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_div_by_zero", div_by_zero, 0);
    checkOutput("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'h1234, 8'h56, 1, '{8'h36, 8'h10, 1'b0, 1'b0});
    waitValid(n);
    checkOutput("latency_normal", n, 8);
    drain();

    applyStimulus(16'hFE01, 8'hFF, 1, '{8'hFF, 8'h00, 1'b0, 1'b0});
    waitValid(n);
    checkOutput("latency_max", n, 8);
    drain();

    applyStimulus(16'h00FF, 8'h01, 1, '{8'hFF, 8'h00, 1'b0, 1'b0});
    drain();

    applyStimulus(16'hABCD, 8'h00, 1, '{8'hFF, 8'hCD, 1'b1, 1'b0});
    waitValid(n);
    checkOutput("latency_div_zero", n, 1);
    drain();

    applyStimulus(16'h0100, 8'h01, 1, '{8'hFF, 8'h00, 1'b0, 1'b1});
    waitValid(n);
    checkOutput("latency_overflow", n, 1);
    drain();

    // Backpressure: result held, new operands ignored until handshake.
    out_ready = 1'b0;
    applyStimulus(16'h1234, 8'h56, 1, '{8'h36, 8'h10, 1'b0, 1'b0});
    waitValid(n);
    in_valid = 1'b1;
    dividend = 16'h00FF;
    divisor  = 8'h10;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_quotient", quotient, 8'h36);
      checkOutput("bp_remainder", remainder, 8'h10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back('{8'h0F, 8'h0F, 1'b0, 1'b0});
    #1;
    in_valid = 1'b0;
    checkOutput("accept_after_release", in_ready, 0);
    waitValid(n);
    checkOutput("latency_after_bp", n, 8);
    drain();

    // Reset in the middle of an operation.
    applyStimulus(16'h1234, 8'h56, 0, '0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    checkOutput("midrst_div_by_zero", div_by_zero, 0);
    checkOutput("midrst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(16'h0064, 8'h0A, 1, '{8'h0A, 8'h00, 1'b0, 1'b0});
    waitValid(n);
    checkOutput("latency_after_rst", n, 8);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 15);
      dvs = 8'($urandom_range(0, 255));
      if (k == 0) dvs = 8'h00;
      if (k == 1 || dvs == 8'h00) hi = 8'($urandom_range(0, 255));
      else                         hi = 8'($urandom_range(0, int'(dvs) - 1));
      dvd = {hi, 8'($urandom_range(0, 255))};
      if (dvs == 8'h00)   e = '{8'hFF, dvd[7:0], 1'b1, 1'b0};
      else if (hi >= dvs) e = '{8'hFF, dvd[7:0], 1'b0, 1'b1};
      else                e = '{8'(dvd / dvs), 8'(dvd % dvs), 1'b0, 1'b0};
      applyStimulus(dvd, dvs, 1, e);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
